// File: rtl/awaddr_wr_arbiter.sv
// Round-robin write-address arbiter: grants one requester at a time into the
// awaddr FIFO and tracks how many write bursts are outstanding.
module awaddr_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 28,
  parameter int LEN_WIDTH  = 8,
  parameter int MAX_OUTST  = 8,
  localparam int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int D_W       = ID_W + LEN_WIDTH + ADDR_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        arb_en,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*LEN_WIDTH-1:0]  req_len,
  output logic [N_REQ-1:0]            req_ready,
  output logic [D_W-1:0]              fifo_wr_data,
  output logic                        fifo_wr_en,
  input  logic                        fifo_wr_vld,
  input  logic                        bdone,
  output logic [7:0]                  outstanding,
  output logic                        busy,
  output logic                        err_underflow
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_OUTST);

  typedef enum logic {IDLE, PUSH} state_t;

  state_t                 state;
  logic [ID_W-1:0]        last_grant;
  logic [ID_W-1:0]        win_idx;
  logic                   win_found;
  logic [ADDR_WIDTH-1:0]  win_addr;
  logic [LEN_WIDTH-1:0]   win_len;
  logic [ID_W-1:0]        winner_q;
  logic                   grant;
  logic                   push_done;

  // Requesters above last_grant take precedence over those at or below it,
  // and the lowest index wins within each group (ascending search with wrap).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (i <= int'(last_grant))) begin
        win_found = 1'b1;
        win_idx   = ID_W'(i);
      end
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (i > int'(last_grant))) begin
        win_found = 1'b1;
        win_idx   = ID_W'(i);
      end
    end
  end

  always_comb begin
    win_addr = '0;
    win_len  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == ID_W'(i)) begin
        win_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_len  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  assign winner_q   = fifo_wr_data[D_W-1 -: ID_W];
  assign grant      = (state == IDLE) && arb_en && win_found && (outstanding < MAX_CNT);
  assign push_done  = (state == PUSH) && fifo_wr_vld;
  assign busy       = (state == PUSH);
  assign fifo_wr_en = (state == PUSH);

  // Acknowledge in the very cycle the FIFO accepts; a reset in that cycle cancels it.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = push_done && !rst && (winner_q == ID_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      fifo_wr_data  <= '0;
      outstanding   <= '0;
      err_underflow <= 1'b0;
      last_grant    <= ID_W'(N_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state        <= PUSH;
            fifo_wr_data <= {win_idx, win_len, win_addr};
          end
        end
        PUSH: begin
          if (fifo_wr_vld) begin
            state      <= IDLE;
            last_grant <= winner_q;
          end
        end
        default: state <= IDLE;
      endcase

      // A completing push and a B response in the same cycle cancel out.
      if (push_done && !bdone) begin
        outstanding <= outstanding + 8'd1;
      end else if (!push_done && bdone) begin
        if (outstanding == 8'd0) begin
          err_underflow <= 1'b1;
        end else begin
          outstanding <= outstanding - 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_awaddr_wr_arbiter.sv
// Directed bench for awaddr_wr_arbiter: expected pushes are queued by the
// stimulus and matched by a negedge monitor against fifo_wr_data/req_ready.
module tb_awaddr_wr_arbiter;

  localparam int N   = 4;
  localparam int AW  = 28;
  localparam int LW  = 8;
  localparam int DW  = 2 + LW + AW;

  logic            clk = 1'b0;
  logic            rst;
  logic            arb_en;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_len;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   fifo_wr_data;
  logic            fifo_wr_en;
  logic            fifo_wr_vld;
  logic            bdone;
  logic [7:0]      outstanding;
  logic            busy;
  logic            err_underflow;

  int checks = 0;
  int errors = 0;
  int pushes_seen = 0;
  int base;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_w;
  logic [N-1:0]  mon_rdy;

  awaddr_wr_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MAX_OUTST(8)) dut (
    .clk(clk), .rst(rst), .arb_en(arb_en), .req_valid(req_valid),
    .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
    .fifo_wr_data(fifo_wr_data), .fifo_wr_en(fifo_wr_en), .fifo_wr_vld(fifo_wr_vld),
    .bdone(bdone), .outstanding(outstanding), .busy(busy), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] addr_of(input int id);
    case (id)
      0: return 28'h0000100;
      1: return 28'h0000200;
      2: return 28'h0001000;
      default: return 28'h0000400;
    endcase
  endfunction

  function automatic logic [LW-1:0] len_of(input int id);
    case (id)
      0: return 8'h00;
      1: return 8'h03;
      2: return 8'h0F;
      default: return 8'h07;
    endcase
  endfunction

  function automatic logic [DW-1:0] word(input int id);
    return {2'(id), len_of(id), addr_of(id)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_reqs();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = addr_of(i);
      req_len[i*LW +: LW]  = len_of(i);
    end
  endtask

  // Monitor: every accepted push must match the head of the expected queue,
  // and req_ready must be the one-hot of that push's id, otherwise zero.
  always @(negedge clk) begin
    mon_rdy = '0;
    if (fifo_wr_en === 1'b1 && fifo_wr_vld === 1'b1 && rst === 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_push: got %0h expected no push", fifo_wr_data);
      end else begin
        mon_w = exp_q.pop_front();
        if (fifo_wr_data !== mon_w) begin
          errors++;
          $display("FAIL push_data: got %0h expected %0h", fifo_wr_data, mon_w);
        end
        mon_rdy = 4'b0001 << mon_w[DW-1 -: 2];
        pushes_seen++;
      end
    end
    checks++;
    if (req_ready !== mon_rdy) begin
      errors++;
      $display("FAIL req_ready: got %b expected %b", req_ready, mon_rdy);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; arb_en = 1'b1; req_valid = '0; req_addr = '0; req_len = '0;
    fifo_wr_vld = 1'b1; bdone = 1'b0;
    load_reqs();
    repeat (2) tick();
    @(negedge clk);
    chk("rst_wr_en", 64'(fifo_wr_en), 64'(0));
    chk("rst_wr_data", 64'(fifo_wr_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_outstanding", 64'(outstanding), 64'(0));
    chk("rst_err", 64'(err_underflow), 64'(0));
    tick();
    rst = 1'b0;

    // Fairness: all requesting, bdone in each IDLE cycle after the first push
    exp_q.push_back(word(0)); exp_q.push_back(word(1)); exp_q.push_back(word(2));
    exp_q.push_back(word(3)); exp_q.push_back(word(0));
    base = pushes_seen;
    req_valid = 4'hF;
    for (int k = 0; k < 10; k++) begin
      bdone = (k >= 2) && (k % 2 == 0);
      tick();
    end
    req_valid = '0;
    bdone = 1'b1;
    @(negedge clk);
    chk("fair_push_count", 64'(pushes_seen - base), 64'(5));
    chk("fair_outstanding", 64'(outstanding), 64'(1));
    tick();
    bdone = 1'b0;
    @(negedge clk);
    chk("fair_drained", 64'(outstanding), 64'(0));

    // Backpressure on requester 2; its inputs change mid-push
    tick();
    fifo_wr_vld = 1'b0;
    req_valid = 4'b0100;
    exp_q.push_back(word(2));
    tick();
    for (int j = 0; j < 5; j++) begin
      if (j == 1) begin
        req_addr[2*AW +: AW] = 28'hABCDEF0;
        req_len[2*LW +: LW]  = 8'h55;
        req_valid = '0;
      end
      @(negedge clk);
      chk("bp_wr_en", 64'(fifo_wr_en), 64'(1));
      chk("bp_busy", 64'(busy), 64'(1));
      chk("bp_wr_data", 64'(fifo_wr_data), 64'(word(2)));
      tick();
    end
    fifo_wr_vld = 1'b1;
    tick();
    load_reqs();
    @(negedge clk);
    chk("bp_idle_wr_en", 64'(fifo_wr_en), 64'(0));
    chk("bp_outstanding", 64'(outstanding), 64'(1));
    bdone = 1'b1;
    tick();
    bdone = 1'b0;

    // Outstanding limit: eight pushes then stall, one bdone lets one more through
    exp_q.push_back(word(3)); exp_q.push_back(word(0)); exp_q.push_back(word(1));
    exp_q.push_back(word(2)); exp_q.push_back(word(3)); exp_q.push_back(word(0));
    exp_q.push_back(word(1)); exp_q.push_back(word(2));
    base = pushes_seen;
    req_valid = 4'hF;
    repeat (20) tick();
    @(negedge clk);
    chk("lim_push_count", 64'(pushes_seen - base), 64'(8));
    chk("lim_outstanding", 64'(outstanding), 64'(8));
    for (int j = 0; j < 3; j++) begin
      tick();
      @(negedge clk);
      chk("lim_stalled", 64'(fifo_wr_en), 64'(0));
    end
    exp_q.push_back(word(3));
    bdone = 1'b1;
    tick();
    bdone = 1'b0;
    @(negedge clk);
    chk("lim_after_bdone_en", 64'(fifo_wr_en), 64'(0));
    chk("lim_after_bdone_cnt", 64'(outstanding), 64'(7));
    tick();
    @(negedge clk);
    chk("lim_regrant_en", 64'(fifo_wr_en), 64'(1));
    req_valid = '0;
    tick();
    @(negedge clk);
    chk("lim_back_to_max", 64'(outstanding), 64'(8));

    // Simultaneous push completion and bdone, then underflow
    bdone = 1'b1;
    repeat (5) tick();
    bdone = 1'b0;
    @(negedge clk);
    chk("sim_at_three", 64'(outstanding), 64'(3));
    req_valid = 4'b0001;
    exp_q.push_back(word(0));
    tick();
    bdone = 1'b1;
    req_valid = '0;
    tick();
    bdone = 1'b0;
    @(negedge clk);
    chk("sim_push_and_bdone", 64'(outstanding), 64'(3));
    bdone = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("sim_zero", 64'(outstanding), 64'(0));
    chk("sim_no_err_yet", 64'(err_underflow), 64'(0));
    tick();
    bdone = 1'b0;
    @(negedge clk);
    chk("uf_count", 64'(outstanding), 64'(0));
    chk("uf_err", 64'(err_underflow), 64'(1));
    repeat (2) tick();
    @(negedge clk);
    chk("uf_sticky", 64'(err_underflow), 64'(1));

    // arb_en dropped during a push: push finishes, then no grants
    tick();
    fifo_wr_vld = 1'b0;
    req_valid = 4'b0010;
    exp_q.push_back(word(1));
    tick();
    arb_en = 1'b0;
    tick();
    fifo_wr_vld = 1'b1;
    tick();
    req_valid = 4'hF;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("arb_off_no_grant", 64'(fifo_wr_en), 64'(0));
      tick();
    end
    chk("arb_off_outstanding", 64'(outstanding), 64'(1));

    // Reset during PUSH with the FIFO accepting: no ack, everything cleared
    arb_en = 1'b1;
    fifo_wr_vld = 1'b0;
    tick();
    rst = 1'b1;
    fifo_wr_vld = 1'b1;
    tick();
    @(negedge clk);
    chk("rstp_wr_en", 64'(fifo_wr_en), 64'(0));
    chk("rstp_wr_data", 64'(fifo_wr_data), 64'(0));
    chk("rstp_busy", 64'(busy), 64'(0));
    chk("rstp_outstanding", 64'(outstanding), 64'(0));
    chk("rstp_err", 64'(err_underflow), 64'(0));
    tick();
    rst = 1'b0;
    exp_q.push_back(word(0));
    tick();
    req_valid = '0;
    tick();
    @(negedge clk);
    chk("post_rst_outstanding", 64'(outstanding), 64'(1));
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
